// File: rtl/wb_cmd_initiator.sv
// Wishbone byte initiator: host command -> classic cycles -> responses.
// Ports: cmd_* host command in, wb_* fabric side, rsp_* host responses out.
module wb_cmd_initiator #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_we,
  input  logic [7:0] cmd_adr,
  input  logic [7:0] cmd_dat,
  input  logic [7:0] cmd_len,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output logic       wb_we_o,
  output logic [7:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_dat,
  output logic       rsp_last,
  output logic       rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } state_t;

  // Counter value seen in the last unacked cycle before abort.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic [7:0]  r_adr;
  logic [7:0]  r_dat;
  logic [7:0]  r_rem;
  logic [15:0] r_tmo;
  logic [7:0]  r_rsp_dat;
  logic        r_rsp_last;
  logic        r_rsp_err;

  logic w_accept;
  logic w_tmo_hit;
  logic w_rem_zero;

  assign w_accept   = cmd_valid & cmd_ready;
  assign w_tmo_hit  = ~wb_ack_i & (r_tmo == TMO_LAST);
  assign w_rem_zero = (r_rem == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_BUS;
      end
      S_BUS: begin
        if (wb_ack_i) begin
          if (!r_we || w_rem_zero) w_next = S_RESP;
        end else if (w_tmo_hit) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) w_next = r_rsp_last ? S_IDLE : S_BUS;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (r_state == S_IDLE) & ~rst;
    wb_stb_o  = (r_state == S_BUS);
    wb_cyc_o  = wb_stb_o;
    wb_we_o   = wb_stb_o & r_we;
    wb_adr_o  = wb_stb_o ? r_adr : 8'd0;
    wb_dat_o  = wb_stb_o ? r_dat : 8'd0;
    rsp_valid = (r_state == S_RESP);
    rsp_dat   = r_rsp_dat;
    rsp_last  = r_rsp_last;
    rsp_err   = r_rsp_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we       <= 1'b0;
      r_adr      <= 8'd0;
      r_dat      <= 8'd0;
      r_rem      <= 8'd0;
      r_tmo      <= 16'd0;
      r_rsp_dat  <= 8'd0;
      r_rsp_last <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we  <= cmd_we;
            r_adr <= cmd_adr;
            r_dat <= cmd_dat;
            r_rem <= cmd_len;
            r_tmo <= 16'd0;
          end
        end
        S_BUS: begin
          if (wb_ack_i) begin
            r_tmo <= 16'd0;
            if (!r_we) begin
              r_rsp_dat  <= wb_dat_i;
              r_rsp_last <= w_rem_zero;
              r_rsp_err  <= 1'b0;
            end else if (!w_rem_zero) begin
              // back-to-back write beat, stb stays high
              r_adr <= r_adr + 8'd1;
              r_rem <= r_rem - 8'd1;
            end else begin
              r_rsp_dat  <= 8'd0;
              r_rsp_last <= 1'b1;
              r_rsp_err  <= 1'b0;
            end
          end else if (w_tmo_hit) begin
            // abort: remaining beats are dropped
            r_rsp_dat  <= 8'd0;
            r_rsp_last <= 1'b1;
            r_rsp_err  <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 16'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready && !r_rsp_last) begin
            r_adr <= r_adr + 8'd1;
            r_rem <= r_rem - 8'd1;
            r_tmo <= 16'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Bench for wb_cmd_initiator: queue scoreboard with a command-level model.
// Random and directed commands against a simple byte responder.
module tb_wb_cmd_initiator;

  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_we;
  logic [7:0] cmd_adr;
  logic [7:0] cmd_dat;
  logic [7:0] cmd_len;
  logic       wb_cyc_o;
  logic       wb_stb_o;
  logic       wb_we_o;
  logic [7:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_ack_i;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_dat;
  logic       rsp_last;
  logic       rsp_err;

  always #5 clk = ~clk;

  wb_cmd_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_adr(cmd_adr),
    .cmd_dat(cmd_dat), .cmd_len(cmd_len),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_dat(rsp_dat), .rsp_last(rsp_last),
    .rsp_err(rsp_err)
  );

  typedef struct packed {
    logic [7:0] dat;
    logic       last;
    logic       err;
  } rsp_t;

  typedef struct packed {
    logic       we;
    logic [7:0] adr;
    logic [7:0] dat;
  } beat_t;

  rsp_t  rq[$];
  beat_t bq[$];
  logic [7:0] mem[256];

  int errs = 0;
  int checks = 0;
  int ack_mode = 0;
  int ack_dly = 0;
  int acnt = 0;
  int stb_cycles = 0;
  bit rr_rand = 1'b0;
  logic rr_force = 1'b1;
  logic rr_bit = 1'b1;

  function automatic void chk(string name, logic [31:0] got,
                              logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  // responder: 0 = ack tied high, 1 = ack after ack_dly waits, 2 = never
  assign wb_dat_i = mem[wb_adr_o];
  always_comb begin
    wb_ack_i = 1'b0;
    case (ack_mode)
      0: wb_ack_i = 1'b1;
      1: wb_ack_i = wb_stb_o && (acnt >= ack_dly);
      default: wb_ack_i = 1'b0;
    endcase
  end

  always @(posedge clk) begin
    if (wb_stb_o && !wb_ack_i) acnt <= acnt + 1;
    else acnt <= 0;
    if (wb_stb_o) stb_cycles <= stb_cycles + 1;
    rr_bit <= ($urandom_range(0, 3) != 0);
  end

  assign rsp_ready = rr_rand ? rr_bit : rr_force;

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_eq_stb", {31'd0, wb_cyc_o}, {31'd0, wb_stb_o});
      if (wb_stb_o && wb_ack_i) begin
        if (bq.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          beat_t b;
          b = bq.pop_front();
          chk("beat_adr", {24'd0, wb_adr_o}, {24'd0, b.adr});
          chk("beat_we", {31'd0, wb_we_o}, {31'd0, b.we});
          if (b.we) chk("beat_dat", {24'd0, wb_dat_o}, {24'd0, b.dat});
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (rq.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          rsp_t e;
          e = rq.pop_front();
          chk("rsp", {22'd0, rsp_dat, rsp_last, rsp_err},
              {22'd0, e.dat, e.last, e.err});
        end
      end
    end
  end

  // reference model: expected beats/responses of one command
  task automatic issue(input logic we, input logic [7:0] adr,
                       input logic [7:0] dat, input logic [7:0] len,
                       input bit tmo);
    int n;
    logic [7:0] a;
    if (tmo) begin
      rq.push_back(rsp_t'{dat: 8'd0, last: 1'b1, err: 1'b1});
    end else begin
      for (int i = 0; i <= int'(len); i++) begin
        a = 8'(int'(adr) + i);
        bq.push_back(beat_t'{we: we, adr: a, dat: dat});
        if (!we)
          rq.push_back(rsp_t'{dat: mem[a], last: (i == int'(len)),
                              err: 1'b0});
      end
      if (we) rq.push_back(rsp_t'{dat: 8'd0, last: 1'b1, err: 1'b0});
    end
    cmd_we = we;
    cmd_adr = adr;
    cmd_dat = dat;
    cmd_len = len;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_we = $urandom_range(0, 1);
    cmd_adr = 8'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(rq.size() == 0 && bq.size() == 0 && cmd_ready)
           && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, {31'd0, cmd_ready}, 32'd1);
    chk({name, "_drained"}, rq.size() + bq.size(), 32'd0);
  endtask

  task automatic wait_rsp(input string name);
    int n;
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, {31'd0, rsp_valid}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    logic [7:0] hd;
    logic       hl;
    logic       he;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_we = 1'b0;
    cmd_adr = 8'd0;
    cmd_dat = 8'd0;
    cmd_len = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("rst_we", {31'd0, wb_we_o}, 32'd0);
    chk("rst_adr", {24'd0, wb_adr_o}, 32'd0);
    chk("rst_rsp", {22'd0, rsp_valid, rsp_dat, rsp_last, rsp_err}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", {31'd0, cmd_ready}, 32'd1);

    // 1: read 4 beats, same-cycle ack, latency check
    mem[0] = 8'h0A; mem[1] = 8'h01; mem[2] = 8'h00; mem[3] = 8'h00;
    ack_mode = 0;
    rr_force = 1'b1;
    issue(1'b0, 8'h00, 8'h00, 8'd3, 1'b0);
    chk("t1_stb_n1", {31'd0, wb_stb_o}, 32'd1);
    chk("t1_adr_n1", {24'd0, wb_adr_o}, 32'd0);
    @(posedge clk); #1;
    chk("t1_rsp_n2", {31'd0, rsp_valid}, 32'd1);
    chk("t1_stb_n2", {31'd0, wb_stb_o}, 32'd0);
    wait_idle("t1_done");

    // 2: write burst, ack tied high
    s0 = stb_cycles;
    issue(1'b1, 8'h10, 8'h5A, 8'd2, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("t2_stb", {31'd0, wb_stb_o}, 32'd1);
      chk("t2_adr", {24'd0, wb_adr_o}, 32'(8'h10 + k));
      @(posedge clk); #1;
    end
    chk("t2_stb_drop", {31'd0, wb_stb_o}, 32'd0);
    chk("t2_rsp", {31'd0, rsp_valid}, 32'd1);
    wait_idle("t2_done");
    chk("t2_stb_cycles", stb_cycles - s0, 32'd3);

    // 3: timeout
    ack_mode = 2;
    rr_force = 1'b0;
    s0 = stb_cycles;
    issue(1'b0, 8'h40, 8'h33, 8'd5, 1'b1);
    wait_rsp("t3_rsp_valid");
    chk("t3_stb_cycles", stb_cycles - s0, TMO);
    chk("t3_ready_busy", {31'd0, cmd_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("t3_rsp_held", {31'd0, rsp_valid}, 32'd1);
    rr_force = 1'b1;
    @(posedge clk); #1;
    chk("t3_ready_back", {31'd0, cmd_ready}, 32'd1);
    wait_idle("t3_done");

    // 4: backpressure with delayed ack
    ack_mode = 1;
    ack_dly = 3;
    rr_force = 1'b0;
    issue(1'b0, 8'h80, 8'h00, 8'd1, 1'b0);
    wait_rsp("t4_rsp_valid");
    hd = rsp_dat;
    hl = rsp_last;
    he = rsp_err;
    s0 = stb_cycles;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("t4_hold", {21'd0, rsp_valid, rsp_dat, rsp_last, rsp_err},
          {21'd0, 1'b1, hd, hl, he});
      chk("t4_no_stb", {31'd0, wb_stb_o}, 32'd0);
    end
    chk("t4_stb_cycles", stb_cycles - s0, 32'd0);
    rr_force = 1'b1;
    wait_idle("t4_done");

    // 5: address wrap
    ack_mode = 0;
    rr_rand = 1'b1;
    issue(1'b0, 8'hFE, 8'h00, 8'd2, 1'b0);
    wait_idle("t5_done");

    // 6: reset in the middle of a read
    rr_rand = 1'b0;
    rr_force = 1'b1;
    issue(1'b0, 8'h20, 8'h00, 8'd3, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_stb_low", {31'd0, wb_stb_o}, 32'd0);
    chk("t6_rsp_low", {31'd0, rsp_valid}, 32'd0);
    chk("t6_ready_in_rst", {31'd0, cmd_ready}, 32'd0);
    rq.delete();
    bq.delete();
    rst = 1'b0;
    #1;
    chk("t6_ready_after", {31'd0, cmd_ready}, 32'd1);
    issue(1'b0, 8'h30, 8'h00, 8'd2, 1'b0);
    wait_idle("t6_done");

    // random commands
    rr_rand = 1'b1;
    for (int it = 0; it < 40; it++) begin
      ack_mode = $urandom_range(0, 1);
      ack_dly = $urandom_range(0, 5);
      issue($urandom_range(0, 1), 8'($urandom), 8'($urandom),
            8'($urandom_range(0, 7)), 1'b0);
      wait_idle("rand_done");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
